// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-master arbiter/sequencer for a single-port byte-write
// SRAM with one-cycle read latency. One access per cycle is accepted, and the read
// data is routed back to the owner in the following cycle.
// Build option: define SRAM_ARB_RR_EN to select round-robin arbitration.
// With the option undefined, master 0 has fixed priority and a starvation guard
// (bounded by STARVE_LIMIT) protects master 1.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned NB_COL       = 4,
  parameter int unsigned COL_WIDTH    = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          m0_req,
  input  logic [NB_COL-1:0]             m0_we,
  input  logic [ADDR_W-1:0]             m0_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   m0_wdata,
  output logic                          m0_gnt,
  output logic                          m0_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   m0_rdata,
  input  logic                          m1_req,
  input  logic [NB_COL-1:0]             m1_we,
  input  logic [ADDR_W-1:0]             m1_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   m1_wdata,
  output logic                          m1_gnt,
  output logic                          m1_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   m1_rdata,
  output logic                          sram_ena,
  output logic [NB_COL-1:0]             sram_wea,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   sram_wdata,
  input  logic [NB_COL*COL_WIDTH-1:0]   sram_rdata
);

  localparam int unsigned DW = NB_COL * COL_WIDTH;

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;

  logic   pick1;
  logic   acc;
  logic   resp_vld;
  owner_t resp_owner;
  logic   resp_rd;

`ifdef SRAM_ARB_RR_EN
  owner_t rr_last;

  // Conflict goes to the master that did not win the last acceptance
  always_comb begin
    pick1 = (rr_last == OWN_M0);
  end

  // Remember the most recent winner, contested or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= OWN_M1;
    end else if (acc) begin
      rr_last <= m1_gnt ? OWN_M1 : OWN_M0;
    end
  end
`else
  localparam int unsigned WC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [WC_W-1:0] wait_cnt;
  logic            starve;

  always_comb begin
    pick1 = starve;
  end

  // Count consecutive m1 losses; a loss seen while the count sits at the limit
  // arms the flag that hands m1 the following conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (m1_req && !m1_gnt) begin
      if (wait_cnt != WC_W'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      starve <= (STARVE_LIMIT != 0) && (wait_cnt == WC_W'(STARVE_LIMIT));
    end else begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end
  end
`endif

  // Grant decision (held off during reset) and SRAM port drive
  always_comb begin
    m0_gnt     = rst_n && m0_req && !(m1_req && pick1);
    m1_gnt     = rst_n && m1_req && !(m0_req && !pick1);
    acc        = m0_gnt || m1_gnt;
    sram_ena   = acc;
    sram_wea   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (m1_gnt) begin
      sram_wea   = m1_we;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end else if (m0_gnt) begin
      sram_wea   = m0_we;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end
  end

  // Track the owner and kind of the access whose response is due next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld   <= 1'b0;
      resp_owner <= OWN_M0;
      resp_rd    <= 1'b0;
    end else begin
      resp_vld   <= acc;
      resp_owner <= m1_gnt ? OWN_M1 : OWN_M0;
      resp_rd    <= acc && (sram_wea == '0);
    end
  end

  // Route the response to its owner; write acks carry zero data
  always_comb begin
    m0_rvalid = resp_vld && (resp_owner == OWN_M0);
    m1_rvalid = resp_vld && (resp_owner == OWN_M1);
    m0_rdata  = (m0_rvalid && resp_rd) ? sram_rdata : DW'(0);
    m1_rdata  = (m1_rvalid && resp_rd) ? sram_rdata : DW'(0);
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM, reference memory,
// response scoreboard, directed scenarios and a random run.
module tb_sram_port_arbiter;

  localparam int LIMIT = 3;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [12:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_ena;
  logic [3:0]  sram_wea;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  sram_port_arbiter #(
    .ADDR_W(13), .NB_COL(4), .COL_WIDTH(8), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte-write SRAM, read-before-write, one-cycle latency
  logic [31:0] mem     [0:8191];
  logic [31:0] ref_mem [0:8191];
  always @(posedge clk) begin
    if (sram_ena) begin
      for (int b = 0; b < 4; b++)
        if (sram_wea[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    bit          owner;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_rv     = 0;

  // Model state and last observations
  bit          g0, g1;
  int          m1_losses;
`ifdef SRAM_ARB_RR_EN
  bit          m_rr_last;
`endif
  logic [1:0]  obs_gnt;
  logic        obs_rv0, obs_rv1, obs_ena;
  logic [31:0] obs_rd0, obs_rd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m1_losses = 0;
`ifdef SRAM_ARB_RR_EN
    m_rr_last = 1'b1;
`endif
  endtask

  // Per-cycle comparison against the reference model, sampled on the falling edge
  task automatic do_checks();
    resp_t       e;
    bit          ev0, ev1, pick1;
    logic [31:0] ed0, ed1, wd;
    logic [3:0]  we;
    logic [12:0] a;
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0; g0 = 0; g1 = 0;
    we = '0; a = '0; wd = '0;
    if (!rst_n) begin
      sb.delete();
      model_reset();
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.owner) begin ev1 = 1; ed1 = e.data; end
      else begin ev0 = 1; ed0 = e.data; end
    end
    check("m0_rvalid", m0_rvalid, ev0);
    check("m1_rvalid", m1_rvalid, ev1);
    check("m0_rdata", m0_rdata, ed0);
    check("m1_rdata", m1_rdata, ed1);
    obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata;  obs_rd1 = m1_rdata;
    obs_gnt = {m1_gnt, m0_gnt};
    obs_ena = sram_ena;
    if (m0_rvalid || m1_rvalid) n_rv++;
    if (rst_n) begin
`ifdef SRAM_ARB_RR_EN
      pick1 = (m_rr_last == 1'b0);
`else
      pick1 = (LIMIT != 0) && (m1_losses > LIMIT);
`endif
      g0 = m0_req && !(m1_req && pick1);
      g1 = m1_req && !(m0_req && !pick1);
    end
    check("m0_gnt", m0_gnt, g0);
    check("m1_gnt", m1_gnt, g1);
    if (g1) begin we = m1_we; a = m1_addr; wd = m1_wdata; end
    else if (g0) begin we = m0_we; a = m0_addr; wd = m0_wdata; end
    check("sram_ena", sram_ena, g0 | g1);
    check("sram_wea", sram_wea, we);
    check("sram_addr", sram_addr, a);
    check("sram_wdata", sram_wdata, wd);
    if (g0 || g1) begin
      e.owner = g1;
      e.data  = (we == 4'b0) ? ref_mem[a] : 32'h0;
      sb.push_back(e);
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
    end
    if (rst_n) begin
`ifdef SRAM_ARB_RR_EN
      if (g0 || g1) m_rr_last = g1;
`else
      m1_losses = (m1_req && !g1) ? m1_losses + 1 : 0;
`endif
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    do_checks();
    @(posedge clk);
    #1;
  endtask

  // Protocol properties over the whole run
  logic prev_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_acc <= 1'b0;
    else        prev_acc <= m0_gnt | m1_gnt;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(m0_gnt && m1_gnt)) else $error("both grants high");
      assert (!(m0_gnt && !m0_req) && !(m1_gnt && !m1_req)) else $error("grant without request");
      assert (!(m0_rvalid && m1_rvalid) && ((m0_rvalid | m1_rvalid) == prev_acc))
        else $error("response count does not match acceptances");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [1:0] seq_tab [0:5];
  int         rv_start;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 32'hA5A5_0000 | i;
      ref_mem[i] = 32'hA5A5_0000 | i;
    end
    mem[32'h20]     = 32'hFFFF_FFFF;
    ref_mem[32'h20] = 32'hFFFF_FFFF;
    sram_rdata = '0;
    m0_req = 0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
    rst_n = 0;
    model_reset();
    repeat (2) cycle();
    rst_n = 1;
    cycle();

    // m0 read of a preloaded word
    m0_req = 1; m0_addr = 13'h10;
    cycle();
    check("t1_gnt", obs_gnt, 2'b01);
    m0_req = 0;
    cycle();
    check("t1_rv0", obs_rv0, 1'b1);
    check("t1_rdata", obs_rd0, 32'hA5A5_0010);
    check("t1_rv1", obs_rv1, 1'b0);

    // m1 partial byte write then read back
    m1_req = 1; m1_we = 4'b0101; m1_addr = 13'h20; m1_wdata = 32'h1122_3344;
    cycle();
    m1_we = 4'b0000; m1_wdata = '0;
    cycle();
    check("t2_wack_rv", obs_rv1, 1'b1);
    check("t2_wack_data", obs_rd1, 32'h0);
    m1_req = 0;
    cycle();
    check("t2_rdata", obs_rd1, 32'hFF22_FF44);

    // Six cycles of continuous contention from a clean reset
`ifdef SRAM_ARB_RR_EN
    seq_tab = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    seq_tab = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    rv_start = n_rv;
    m0_req = 1; m0_addr = 13'h100;
    m1_req = 1; m1_addr = 13'h200;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("conf_seq%0d", i), obs_gnt, seq_tab[i]);
      if (g0) m0_addr = m0_addr + 13'd1;
      if (g1) m1_addr = m1_addr + 13'd1;
    end
    m0_req = 0; m1_req = 0;
    cycle();
    check("conf_resp_cnt", n_rv - rv_start, 6);

    // Back-to-back m0 reads with no bubbles
    for (int k = 1; k <= 4; k++) begin
      m0_req = (k <= 3);
      m0_addr = 13'(k);
      cycle();
      if (k >= 2) begin
        check($sformatf("b2b_rv%0d", k - 1), obs_rv0, 1'b1);
        check($sformatf("b2b_data%0d", k - 1), obs_rd0, 32'hA5A5_0000 | (k - 1));
      end
    end
    m0_req = 0;

    // Reset while a read response is in flight
    m0_req = 1; m0_addr = 13'h10;
    cycle();
    check("rst_acc", obs_gnt, 2'b01);
    rst_n = 0; m1_req = 1;
    cycle();
    check("rst_rv0", obs_rv0, 1'b0);
    check("rst_ena", obs_ena, 1'b0);
    check("rst_gnt", obs_gnt, 2'b00);
    rst_n = 1;
    cycle();
    check("rst_no_stale", obs_rv0 | obs_rv1, 1'b0);
    check("rst_first_conf", obs_gnt, 2'b01);
    m0_req = 0; m1_req = 0;
    cycle();

    // Random traffic; payload is held until the model says it was granted
    for (int i = 0; i < 400; i++) begin
      if (!m0_req || g0) begin
        m0_req   = 1'($urandom_range(0, 1));
        m0_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
        m0_addr  = 13'($urandom_range(0, 63));
        m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req   = 1'($urandom_range(0, 1));
        m1_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
        m1_addr  = 13'($urandom_range(0, 63));
        m1_wdata = $urandom;
      end
      cycle();
    end
    m0_req = 0; m1_req = 0;
    cycle();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
